// File: rtl/gray_to_binary_serial_ctrl.sv
// ============================================================================
// gray_to_binary_serial_ctrl
// ----------------------------------------------------------------------------
// Bit-serial Gray-to-binary conversion controller with valid/ready handshakes
// on both the source and consumer sides.
//
// One Gray word is latched on the input handshake. The XOR chain
// b[i] = b[i+1] ^ g[i] is then evaluated one bit per clock, MSB first, into
// the registered result. The result is held with out_valid high until the
// consumer accepts it. This block is intended to sit between a Gray-coded
// source (for example a CDC pointer) and binary-domain logic where area
// matters more than latency.
//
// Parameters
//   WIDTH       Gray/binary word width in bits (legal range 2..32).
//
// Ports
//   clk         in   1      Rising-edge clock.
//   rst         in   1      Asynchronous, active-high reset.
//   in_valid    in   1      Source presents gray_in.
//   in_ready    out  1      Controller can accept a word (state is IDLE).
//   gray_in     in   WIDTH  Gray-coded input word.
//   out_valid   out  1      bin_out holds a completed conversion.
//   out_ready   in   1      Consumer accepts bin_out.
//   bin_out     out  WIDTH  Binary result (registered).
//   busy        out  1      Controller is not IDLE.
//
// Build option
//   GRAY_PARALLEL_EN  When defined, the conversion state lasts a single cycle
//                     and the whole XOR-prefix is written in one edge; the
//                     bit index counter is not built. Handshakes unchanged.
//                     When undefined (default), the bit-serial datapath is
//                     used.
// ============================================================================
module gray_to_binary_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // Latched copy of the Gray word; the live gray_in is ignored after accept.
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    // Registered binary result, written bit by bit during conversion.
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;

    logic             out_valid_q;
    logic             out_valid_d;

    logic             accept;

`ifdef GRAY_PARALLEL_EN
    // ------------------------------------------------------------------------
    // Full XOR-prefix: each binary bit is the XOR of all Gray bits at and
    // above its position.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] gray_prefix(
        input logic [WIDTH-1:0] gray
    );
        logic [WIDTH-1:0] res;
        logic             acc;
        res = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            res[i] = acc;
        end
        return res;
    endfunction
`else
    // Bit index down-counter: starts at the MSB, stops at 0 (never wraps).
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // ------------------------------------------------------------------------
    // One step of the serial XOR chain: write bit idx of the result as
    // gray[idx] ^ bin[idx+1]. Shifting the current result down by one with a
    // zero fill makes the MSB case (no upper neighbour) fall out naturally,
    // since gray[MSB] ^ 0 == gray[MSB]. All other bits are returned
    // unchanged, so not-yet-written bits keep their stale contents.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] serial_step(
        input logic [WIDTH-1:0] bin,
        input logic [WIDTH-1:0] gray,
        input logic [IDX_W-1:0] idx
    );
        logic [WIDTH-1:0] upper;
        logic [WIDTH-1:0] res;
        upper = {1'b0, bin[WIDTH-1:1]};
        res   = bin;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == IDX_W'(i)) begin
                res[i] = gray[i] ^ upper[i];
            end
        end
        return res;
    endfunction
`endif

    assign accept = in_valid && (state_q == ST_IDLE);

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gray_d      = gray_q;
        bin_d       = bin_q;
        out_valid_d = out_valid_q;
`ifndef GRAY_PARALLEL_EN
        idx_d       = idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gray_d  = gray_in;
`ifndef GRAY_PARALLEL_EN
                    idx_d   = IDX_MSB;
`endif
                    state_d = ST_CONV;
                end
            end

            ST_CONV: begin
`ifdef GRAY_PARALLEL_EN
                bin_d       = gray_prefix(gray_q);
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
`else
                bin_d = serial_step(bin_q, gray_q, idx_q);
                if (idx_q == IDX_ZERO) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
`endif
            end

            ST_DONE: begin
                // out_valid is high throughout DONE, so out_ready alone
                // completes the handshake; out_ready elsewhere is ignored.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers; reset discards any in-flight word immediately.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gray_q      <= '0;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
`ifndef GRAY_PARALLEL_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gray_q      <= gray_d;
            bin_q       <= bin_d;
            out_valid_q <= out_valid_d;
`ifndef GRAY_PARALLEL_EN
            idx_q       <= idx_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;

endmodule

// File: tb/tb_gray_to_binary_serial_ctrl.sv
module tb_gray_to_binary_serial_ctrl;

    localparam int WIDTH = 4;
`ifdef GRAY_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             busy;

    int n_checks;
    int n_err;
    int cyc;

    gray_to_binary_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept g, wait LAT edges, check result, then complete the handshake.
    task automatic run_word(input string tag, input logic [WIDTH-1:0] g,
                            input logic [WIDTH-1:0] exp);
        gray_in   = g;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT) check({tag, "_early"}, 32'(out_valid), 32'd0);
        end
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_bin"}, 32'(bin_out), 32'(exp));
        tick();
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    int t_acc;
    int t_prev;

    initial begin
        n_checks  = 0;
        n_err     = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gray_in   = '0;
        #3;
        check("rst_vld",  32'(out_valid), 32'd0);
        check("rst_bin",  32'(bin_out),   32'd0);
        check("rst_rdy",  32'(in_ready),  32'd1);
        check("rst_busy", 32'(busy),      32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a conversion
        gray_in  = 4'b1110;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_busy", 32'(busy),     32'd1);
        check("t1_nrdy", 32'(in_ready), 32'd0);
`ifndef GRAY_PARALLEL_EN
        tick();
        tick();
        check("t1_part", 32'(bin_out[3:2]), 32'b10);
`endif
        #2 rst = 1'b1;
        #1;
        check("t1_rvld", 32'(out_valid), 32'd0);
        check("t1_rbin", 32'(bin_out),   32'd0);
        check("t1_rrdy", 32'(in_ready),  32'd1);
        #1 rst = 1'b0;
        for (int k = 0; k < WIDTH + 1; k++) begin
            tick();
            check("t1_noout", 32'(out_valid), 32'd0);
        end

        // 2: single word 0011 -> 0010 with exact latency
        gray_in   = 4'b0011;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("t2_busy", 32'(busy), 32'd1);
            if (k < LAT) check("t2_early", 32'(out_valid), 32'd0);
        end
        check("t2_vld", 32'(out_valid), 32'd1);
        check("t2_bin", 32'(bin_out),   32'b0010);
        tick();
        check("t2_hs_vld", 32'(out_valid), 32'd0);
        check("t2_hs_rdy", 32'(in_ready),  32'd1);
        check("t2_hold",   32'(bin_out),   32'b0010);

        // 3: back-to-back words, in_valid/out_ready held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t_prev    = 0;
        for (int w = 0; w < 4; w++) begin
            logic [WIDTH-1:0] g;
            logic [WIDTH-1:0] e;
            case (w)
                0:       begin g = 4'b0110; e = 4'b0100; end
                1:       begin g = 4'b1110; e = 4'b1011; end
                2:       begin g = 4'b1100; e = 4'b1000; end
                default: begin g = 4'b1101; e = 4'b1001; end
            endcase
            gray_in = g;
            check("t3_rdy", 32'(in_ready), 32'd1);
            tick();
            t_acc = cyc;
            if (w > 0) check("t3_period", 32'(t_acc - t_prev), 32'(LAT + 2));
            t_prev = t_acc;
            for (int k = 0; k < LAT; k++) tick();
            check("t3_vld", 32'(out_valid), 32'd1);
            check("t3_bin", 32'(bin_out),   32'(e));
            tick();
        end
        in_valid = 1'b0;
        tick();

        // 4: input changes during CONV ignored; result held under backpressure
        gray_in   = 4'b1101;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        gray_in = 4'b0000;
        for (int k = 0; k < LAT; k++) tick();
        check("t4_vld", 32'(out_valid), 32'd1);
        check("t4_bin", 32'(bin_out),   32'b1001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hvld", 32'(out_valid), 32'd1);
            check("t4_hbin", 32'(bin_out),   32'b1001);
            check("t4_hrdy", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_hs_vld", 32'(out_valid), 32'd0);
        check("t4_hs_rdy", 32'(in_ready),  32'd1);

        // 5: all-zero word, plus the parallel-mode vector
        run_word("t5_zero", 4'b0000, 4'b0000);
`ifdef GRAY_PARALLEL_EN
        run_word("t5_par", 4'b1110, 4'b1011);
`endif
        run_word("t5_ones", 4'b1111, 4'b1010);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
